rvv_backend_dispatch_vrf_scoreboard: RTL and testbench

Per-register in-flight write scoreboard for the RVV backend dispatch stage. Tracks how many dispatched-but-not-written-back uops target each of the 32 VRF registers. Resolves RAW hazards for up to DISP_NUM uops per cycle against in-flight uops and against older uops in the same dispatch group. Returns an in-order ready prefix to the dispatch controller.

---
 rtl/rvv_backend_dispatch_vrf_scoreboard.sv | 137 +++++++++++++
 tb/tb_rvv_backend_dispatch_vrf_scoreboard.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_dispatch_vrf_scoreboard.sv
// Per-register in-flight write counters for the RVV dispatch stage; resolves RAW
// hazards against in-flight and older same-group uops and returns an in-order ready prefix.
module rvv_backend_dispatch_vrf_scoreboard #(
    parameter int DISP_NUM = 2,
    parameter int WB_NUM   = 2,
    parameter int CNT_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DISP_NUM-1:0]   uop_valid,
    input  logic [DISP_NUM*5-1:0] uop_vs1_index,
    input  logic [DISP_NUM-1:0]   uop_vs1_valid,
    input  logic [DISP_NUM*5-1:0] uop_vs2_index,
    input  logic [DISP_NUM-1:0]   uop_vs2_valid,
    input  logic [DISP_NUM*5-1:0] uop_vd_index,
    input  logic [DISP_NUM-1:0]   uop_vs3_valid,
    input  logic [DISP_NUM-1:0]   uop_vm,
    input  logic [DISP_NUM-1:0]   uop_w_vrf,
    output logic [DISP_NUM-1:0]   uop_ready,
    input  logic [DISP_NUM-1:0]   uop_fire,
    input  logic [WB_NUM-1:0]     wb_valid,
    input  logic [WB_NUM*5-1:0]   wb_index,
    output logic [31:0]           pending_vec,
    output logic                  busy,
    output logic                  err_underflow
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Handshake: a slot transfers when uop_fire[i]; the controller only fires slots
    // with uop_valid[i] & uop_ready[i], and ready never depends on fire.

    logic [CNT_W-1:0] r_cnt [32];
    logic [31:0]      r_pending;
    logic             r_err;

    logic [4:0]       w_vs1 [DISP_NUM];
    logic [4:0]       w_vs2 [DISP_NUM];
    logic [4:0]       w_vd  [DISP_NUM];
    logic [4:0]       w_wb  [WB_NUM];
    logic [DISP_NUM-1:0] w_hit;
    logic [DISP_NUM-1:0] w_ready;
    logic             w_prev;
    int               w_older;
    logic [CNT_W-1:0] w_cnt_nxt [32];
    logic [31:0]      w_under;
    int               w_inc;
    int               w_dec;
    int               w_sum;

    for (genvar g = 0; g < DISP_NUM; g++) begin : g_slot
        assign w_vs1[g] = uop_vs1_index[g*5 +: 5];
        assign w_vs2[g] = uop_vs2_index[g*5 +: 5];
        assign w_vd[g]  = uop_vd_index[g*5 +: 5];
    end

    for (genvar g = 0; g < WB_NUM; g++) begin : g_wb
        assign w_wb[g] = wb_index[g*5 +: 5];
    end

    // Hazards use current counters only: a writeback landing this cycle does not bypass.
    always_comb begin
        w_hit   = '0;
        w_ready = '0;
        w_prev  = 1'b1;
        w_older = 0;
        for (int i = 0; i < DISP_NUM; i++) begin
            w_older = 0;
            if (uop_vs1_valid[i] && r_cnt[w_vs1[i]] != '0) w_hit[i] = 1'b1;
            if (uop_vs2_valid[i] && r_cnt[w_vs2[i]] != '0) w_hit[i] = 1'b1;
            if (uop_vs3_valid[i] && r_cnt[w_vd[i]]  != '0) w_hit[i] = 1'b1;
            if (!uop_vm[i]       && r_cnt[0]        != '0) w_hit[i] = 1'b1;
            for (int j = 0; j < DISP_NUM; j++) begin
                if (j < i && uop_valid[j] && uop_w_vrf[j]) begin
                    if (uop_vs1_valid[i] && w_vd[j] == w_vs1[i]) w_hit[i] = 1'b1;
                    if (uop_vs2_valid[i] && w_vd[j] == w_vs2[i]) w_hit[i] = 1'b1;
                    if (uop_vs3_valid[i] && w_vd[j] == w_vd[i])  w_hit[i] = 1'b1;
                    if (!uop_vm[i]       && w_vd[j] == 5'd0)     w_hit[i] = 1'b1;
                    if (w_vd[j] == w_vd[i]) w_older = w_older + 1;
                end
            end
            if (uop_w_vrf[i] && (int'(r_cnt[w_vd[i]]) + w_older + 1 > CNT_MAX))
                w_hit[i] = 1'b1;
            w_ready[i] = uop_valid[i] & ~w_hit[i] & w_prev & ~flush;
            w_prev     = w_ready[i];
        end
    end

    // Net increment/decrement per register; underflow clamps to zero and is flagged.
    always_comb begin
        w_under = '0;
        w_inc   = 0;
        w_dec   = 0;
        w_sum   = 0;
        for (int r = 0; r < 32; r++) begin
            w_inc = 0;
            w_dec = 0;
            for (int i = 0; i < DISP_NUM; i++)
                if (uop_fire[i] && uop_w_vrf[i] && w_vd[i] == 5'(r)) w_inc = w_inc + 1;
            for (int k = 0; k < WB_NUM; k++)
                if (wb_valid[k] && w_wb[k] == 5'(r)) w_dec = w_dec + 1;
            w_sum = int'(r_cnt[r]) + w_inc - w_dec;
            if (w_sum < 0) begin
                w_cnt_nxt[r] = '0;
                w_under[r]   = 1'b1;
            end else if (w_sum > CNT_MAX) begin
                w_cnt_nxt[r] = CNT_W'(CNT_MAX);
            end else begin
                w_cnt_nxt[r] = CNT_W'(w_sum);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
            r_pending <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                r_cnt[r]     <= w_cnt_nxt[r];
                r_pending[r] <= (w_cnt_nxt[r] != '0);
            end
            r_err <= r_err | (|w_under);
        end
    end

    assign uop_ready     = w_ready;
    assign pending_vec   = r_pending;
    assign busy          = |r_pending;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_rvv_backend_dispatch_vrf_scoreboard.sv
// Directed bench for the dispatch VRF scoreboard: hazards, saturation, underflow, flush, reset.
module tb_rvv_backend_dispatch_vrf_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  uop_valid, uop_vs1_valid, uop_vs2_valid, uop_vs3_valid, uop_vm, uop_w_vrf, uop_fire;
    logic [9:0]  uop_vs1_index, uop_vs2_index, uop_vd_index;
    logic [1:0]  uop_ready;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_index;
    logic [31:0] pending_vec;
    logic        busy;
    logic        err_underflow;

    int n_cmp = 0;
    int n_err = 0;

    rvv_backend_dispatch_vrf_scoreboard #(.DISP_NUM(2), .WB_NUM(2), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .uop_valid(uop_valid), .uop_vs1_index(uop_vs1_index), .uop_vs1_valid(uop_vs1_valid),
        .uop_vs2_index(uop_vs2_index), .uop_vs2_valid(uop_vs2_valid),
        .uop_vd_index(uop_vd_index), .uop_vs3_valid(uop_vs3_valid),
        .uop_vm(uop_vm), .uop_w_vrf(uop_w_vrf), .uop_ready(uop_ready), .uop_fire(uop_fire),
        .wb_valid(wb_valid), .wb_index(wb_index),
        .pending_vec(pending_vec), .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic clear_in();
        uop_valid = '0; uop_vs1_valid = '0; uop_vs2_valid = '0; uop_vs3_valid = '0;
        uop_vm = 2'b11; uop_w_vrf = '0; uop_fire = '0;
        uop_vs1_index = '0; uop_vs2_index = '0; uop_vd_index = '0;
        wb_valid = '0; wb_index = '0; flush = 1'b0;
    endtask

    task automatic set_slot(input int s, input logic [4:0] vs1, input logic vs1v,
                            input logic [4:0] vs2, input logic vs2v, input logic [4:0] vd,
                            input logic vs3v, input logic vm, input logic wr);
        uop_valid[s] = 1'b1;
        uop_vs1_index[s*5 +: 5] = vs1; uop_vs1_valid[s] = vs1v;
        uop_vs2_index[s*5 +: 5] = vs2; uop_vs2_valid[s] = vs2v;
        uop_vd_index[s*5 +: 5]  = vd;  uop_vs3_valid[s] = vs3v;
        uop_vm[s] = vm; uop_w_vrf[s] = wr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_write(input logic [4:0] r);
        clear_in();
        set_slot(0, 5'd0, 1'b0, 5'd0, 1'b0, r, 1'b0, 1'b1, 1'b1);
        uop_fire = 2'b01;
        step();
        clear_in();
    endtask

    task automatic do_wb(input logic [4:0] r);
        wb_valid = 2'b01; wb_index[4:0] = r;
        step();
        wb_valid = '0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0; #2;
        rst_n = 1'b1; #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (pending_vec !== 32'h0) begin $display("FAIL reset_pending got=%h exp=%h", pending_vec, 32'h0); n_err++; end
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); n_err++; end
        n_cmp++; if (err_underflow !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", err_underflow); n_err++; end
        n_cmp++; if (uop_ready !== 2'b00) begin $display("FAIL reset_ready got=%b exp=00", uop_ready); n_err++; end
    endtask

    task automatic test_basic();
        clear_in();
        set_slot(0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n_cmp++; if (uop_ready !== 2'b01) begin $display("FAIL basic_free got=%b exp=01", uop_ready); n_err++; end
        fire_write(5'd3);
        n_cmp++; if (pending_vec !== 32'h8) begin $display("FAIL basic_pending got=%h exp=%h", pending_vec, 32'h8); n_err++; end
        n_cmp++; if (busy !== 1'b1) begin $display("FAIL basic_busy got=%b exp=1", busy); n_err++; end
        set_slot(0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n_cmp++; if (uop_ready !== 2'b00) begin $display("FAIL basic_blocked got=%b exp=00", uop_ready); n_err++; end
        do_wb(5'd3);
        n_cmp++; if (pending_vec !== 32'h0) begin $display("FAIL basic_wb_pending got=%h exp=0", pending_vec); n_err++; end
        n_cmp++; if (uop_ready !== 2'b01) begin $display("FAIL basic_unblock got=%b exp=01", uop_ready); n_err++; end
    endtask

    task automatic test_same_group();
        clear_in();
        set_slot(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1);
        set_slot(1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0);
        #1;
        n_cmp++; if (uop_ready !== 2'b01) begin $display("FAIL group_raw got=%b exp=01", uop_ready); n_err++; end
        fire_write(5'd7);
        set_slot(0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0);
        set_slot(1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
        #1;
        n_cmp++; if (uop_ready !== 2'b00) begin $display("FAIL group_inorder got=%b exp=00", uop_ready); n_err++; end
        do_wb(5'd7);
        n_cmp++; if (uop_ready !== 2'b11) begin $display("FAIL group_both got=%b exp=11", uop_ready); n_err++; end
    endtask

    task automatic test_mask();
        fire_write(5'd0);
        set_slot(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (uop_ready !== 2'b00) begin $display("FAIL mask_v0_busy got=%b exp=00", uop_ready); n_err++; end
        uop_vm[0] = 1'b1;
        #1;
        n_cmp++; if (uop_ready !== 2'b01) begin $display("FAIL mask_unmasked got=%b exp=01", uop_ready); n_err++; end
        uop_vm[0] = 1'b0;
        do_wb(5'd0);
        n_cmp++; if (uop_ready !== 2'b01) begin $display("FAIL mask_v0_free got=%b exp=01", uop_ready); n_err++; end
        clear_in();
    endtask

    task automatic test_saturation();
        fire_write(5'd9);
        fire_write(5'd9);
        set_slot(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1);
        set_slot(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1);
        #1;
        n_cmp++; if (uop_ready !== 2'b01) begin $display("FAIL sat_group_ovf got=%b exp=01", uop_ready); n_err++; end
        uop_fire = 2'b01;
        step();
        clear_in();
        set_slot(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1);
        #1;
        n_cmp++; if (uop_ready !== 2'b00) begin $display("FAIL sat_full got=%b exp=00", uop_ready); n_err++; end
        uop_fire = 2'b01; wb_valid = 2'b01; wb_index[4:0] = 5'd9;
        step();
        uop_fire = '0; wb_valid = '0;
        n_cmp++; if (pending_vec[9] !== 1'b1) begin $display("FAIL sat_net_pending got=%b exp=1", pending_vec[9]); n_err++; end
        n_cmp++; if (uop_ready !== 2'b00) begin $display("FAIL sat_net_still_full got=%b exp=00", uop_ready); n_err++; end
        do_wb(5'd9);
        n_cmp++; if (uop_ready !== 2'b01) begin $display("FAIL sat_room got=%b exp=01", uop_ready); n_err++; end
        wb_valid = 2'b11; wb_index = {5'd9, 5'd9};
        step();
        wb_valid = '0;
        n_cmp++; if (pending_vec !== 32'h0) begin $display("FAIL sat_drain got=%h exp=0", pending_vec); n_err++; end
        n_cmp++; if (err_underflow !== 1'b0) begin $display("FAIL sat_no_err got=%b exp=0", err_underflow); n_err++; end
        clear_in();
    endtask

    task automatic test_flush();
        clear_in();
        set_slot(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1);
        set_slot(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1);
        #1;
        n_cmp++; if (uop_ready !== 2'b11) begin $display("FAIL flush_setup_ready got=%b exp=11", uop_ready); n_err++; end
        uop_fire = 2'b11;
        step();
        clear_in();
        n_cmp++; if (pending_vec !== 32'h12) begin $display("FAIL flush_setup_pending got=%h exp=%h", pending_vec, 32'h12); n_err++; end
        flush = 1'b1;
        set_slot(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b1);
        #1;
        n_cmp++; if (uop_ready !== 2'b00) begin $display("FAIL flush_ready got=%b exp=00", uop_ready); n_err++; end
        uop_fire = 2'b01; wb_valid = 2'b01; wb_index[4:0] = 5'd9;
        step();
        clear_in();
        n_cmp++; if (pending_vec !== 32'h0) begin $display("FAIL flush_pending got=%h exp=0", pending_vec); n_err++; end
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL flush_busy got=%b exp=0", busy); n_err++; end
        n_cmp++; if (err_underflow !== 1'b0) begin $display("FAIL flush_err got=%b exp=0", err_underflow); n_err++; end
    endtask

    task automatic test_underflow();
        clear_in();
        do_wb(5'd2);
        n_cmp++; if (err_underflow !== 1'b1) begin $display("FAIL uf_set got=%b exp=1", err_underflow); n_err++; end
        n_cmp++; if (pending_vec !== 32'h0) begin $display("FAIL uf_clamp got=%h exp=0", pending_vec); n_err++; end
        step(); step();
        n_cmp++; if (err_underflow !== 1'b1) begin $display("FAIL uf_sticky got=%b exp=1", err_underflow); n_err++; end
        fire_write(5'd2);
        n_cmp++; if (pending_vec !== 32'h4) begin $display("FAIL uf_count_one got=%h exp=%h", pending_vec, 32'h4); n_err++; end
        do_wb(5'd2);
        n_cmp++; if (pending_vec !== 32'h0) begin $display("FAIL uf_count_zero got=%h exp=0", pending_vec); n_err++; end
        pulse_reset();
        n_cmp++; if (err_underflow !== 1'b0) begin $display("FAIL uf_reset got=%b exp=0", err_underflow); n_err++; end
    endtask

    task automatic test_async_reset();
        fire_write(5'd11);
        n_cmp++; if (pending_vec !== 32'h800) begin $display("FAIL ar_pending got=%h exp=%h", pending_vec, 32'h800); n_err++; end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pending_vec !== 32'h0) begin $display("FAIL ar_pending_clr got=%h exp=0", pending_vec); n_err++; end
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL ar_busy_clr got=%b exp=0", busy); n_err++; end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        #12;
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_same_group();
        test_mask();
        test_saturation();
        test_flush();
        test_underflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
